// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like data-side memory responder.
package sram_like_pkg;

    localparam int WORD_W = 32;
    localparam int CD_W   = 3;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [CD_W-1:0]   countdown;
    } resp_entry_t;

    // A half must sit on an even address, a word on a multiple of four,
    // and the reserved size encoding is always treated as misaligned.
    function automatic logic isMisaligned(input logic [1:0] sizeEnc, input logic [1:0] lowAddr);
        logic bad;
        bad = 1'b0;
        case (size_e'(sizeEnc))
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lowAddr[0];
            SIZE_WORD: bad = |lowAddr;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_like_slave_resp_fifo.sv
// Synchronous circular FIFO holding response payloads in acceptance order.
// Pointers are exported so the owner can keep per-slot side state.
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o,
    output logic [PTR_W-1:0] wrPtr_o,
    output logic [PTR_W-1:0] rdPtr_o
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = store_q[rdPtr_q];
    assign wrPtr_o = wrPtr_q;
    assign rdPtr_o = rdPtr_q;

    // Pushing into a full FIFO is only legal when the head leaves the same cycle.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Next pointer and occupancy values; a simultaneous push and pop keeps the count.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (doPop) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy decides which slots are live.
    always_ff @(posedge clk) begin
        if (doPush) begin
            store_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// Data-side memory responder for an SRAM-like req/addr_ok, data_ok/rdata channel.
// Requests complete in order after a fixed latency; writes land at acceptance.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [3:0]        wstrb,
    input  logic [WORD_W-1:0] wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [CD_W-1:0]   cd_q [QUEUE_DEPTH];

    logic              dataOk_q, dataOk_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    logic [WORD_W-1:0] fifoHead;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    resp_entry_t       headEntry;
    logic              push;
    logic              pop;
    logic              inRange;
    logic [IDX_W-1:0]  wordIdx;
    logic [WORD_W-1:0] pushData;

    assign headEntry = '{data: fifoHead, countdown: cd_q[rdPtr]};

    // Acceptance depends only on registered occupancy and the head countdown, never on req.
    assign pop     = !fifoEmpty && (headEntry.countdown == '0);
    assign addr_ok = !fifoFull || pop;
    assign push    = req && addr_ok && !reset;

    assign inRange  = ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    assign wordIdx  = addr[IDX_W+1:2];
    assign pushData = (wr || !inRange) ? '0 : mem[wordIdx];

    resp_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (WORD_W)
    ) u_respFifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pushData_i (pushData),
        .pop_i      (pop),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount),
        .head_o     (fifoHead),
        .wrPtr_o    (wrPtr),
        .rdPtr_o    (rdPtr)
    );

    // Backing store: strobed byte writes at the acceptance edge; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (push && wr && inRange) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[wordIdx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Countdowns sit beside the FIFO so every live slot ticks each cycle; a push reloads its slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (push && (wrPtr == PTR_W'(i))) begin
                    cd_q[i] <= CD_W'(LATENCY - 1);
                end else if ((int'(PTR_W'(PTR_W'(i) - rdPtr)) < int'(fifoCount)) && (cd_q[i] != '0)) begin
                    cd_q[i] <= cd_q[i] - 1'b1;
                end
            end
        end
    end

    // Response and sticky error next-state: rdata only moves when a response leaves.
    always_comb begin
        dataOk_d = pop;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (pop) begin
            rdata_d = headEntry.data;
        end
        if (push && (!inRange || isMisaligned(size, addr[1:0]))) begin
            err_d = 1'b1;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOk_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            dataOk_q <= dataOk_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign data_ok = dataOk_q;
    assign rdata   = rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sram_like_slave.sv
// Self-checking bench for sram_like_slave: directed requests push their expected
// response into a queue, and an independent monitor pops it when data_ok appears.
module tb_sram_like_slave;

   localparam int LAT = 4;
   localparam int QD  = 2;
   localparam int DW  = 64;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        req   = 1'b0;
   logic        wr    = 1'b0;
   logic [1:0]  size  = 2'd2;
   logic [31:0] addr  = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic        addrOk;
   logic        dataOk;
   logic [31:0] rdata;
   logic        err;

   int checkCount = 0;
   int errorCount = 0;
   int edgeCount  = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t expQ[$];
   exp_t monEntry;

   sram_like_slave #(
      .DEPTH_WORDS (DW),
      .LATENCY     (LAT),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .wr      (wr),
      .size    (size),
      .addr    (addr),
      .wstrb   (wstrb),
      .wdata   (wdata),
      .addr_ok (addrOk),
      .data_ok (dataOk),
      .rdata   (rdata),
      .err     (err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Count rising edges so expected response times can be stated in edges.
   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Compare one value and report any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every data_ok must match the oldest outstanding expectation in data and timing,
   // and an expectation whose time has passed without a response is reported as missing.
   always @(negedge clk) begin
      if (dataOk) begin
         if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpectedDataOk: got data_ok=1 at edge %0d, expected no response", edgeCount);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("respData", rdata, monEntry.data);
            checkOutput("respEdge", 32'(edgeCount), 32'(monEntry.due));
         end
      end else if (expQ.size() > 0 && expQ[0].due < edgeCount) begin
         monEntry = expQ.pop_front();
         checkCount++;
         errorCount++;
         $display("[TB] FAIL missingDataOk: got no response by edge %0d, expected one at edge %0d", edgeCount, monEntry.due);
      end
   end

   // Present one request and hold it until accepted; the expected response is queued
   // for the edge LAT edges after the acceptance edge.
   task automatic applyStimulus(input logic isWr, input logic [1:0] sz, input logic [31:0] a,
                                input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] expData);
      int guard = 0;
      @(negedge clk);
      req   = 1'b1;
      wr    = isWr;
      size  = sz;
      addr  = a;
      wstrb = strb;
      wdata = wd;
      while (!addrOk && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!addrOk) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL acceptTimeout: got addr_ok=0 for 20 cycles, expected 1 (addr 0x%08h)", a);
         req = 1'b0;
      end else begin
         expQ.push_back('{expData, edgeCount + 1 + LAT});
      end
   endtask

   // Stop requesting and wait, bounded, for all outstanding responses.
   task automatic drain();
      int guard = 0;
      @(negedge clk);
      req = 1'b0;
      while (expQ.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (expQ.size() > 0) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL drainTimeout: got %0d responses outstanding, expected 0", expQ.size());
         expQ.delete();
      end
   endtask

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, expected the bench to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      logic [9:0] pattern;
      int         accepted;

      // Reset state, with req deliberately high during reset.
      req = 1'b1;
      wr  = 1'b1;
      wstrb = 4'hF;
      wdata = 32'hFFFF_FFFF;
      addr  = 32'h10;
      repeat (3) @(negedge clk);
      req   = 1'b0;
      reset = 1'b0;
      checkOutput("resetAddrOk", {31'b0, addrOk}, 32'h1);
      checkOutput("resetDataOk", {31'b0, dataOk}, 32'h0);
      checkOutput("resetRdata", rdata, 32'h0);
      checkOutput("resetErr", {31'b0, err}, 32'h0);

      // Word write then read back.
      applyStimulus(1'b1, 2'd2, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
      drain();

      // Single byte-lane strobe merges into an existing word.
      applyStimulus(1'b1, 2'd2, 32'h20, 4'hF, 32'h1122_3344, 32'h0);
      applyStimulus(1'b1, 2'd0, 32'h22, 4'b0100, 32'h00AA_0000, 32'h0);
      applyStimulus(1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 32'h11AA_3344);
      drain();
      checkOutput("strobeErr", {31'b0, err}, 32'h0);

      // Aligned byte and half writes build up a word.
      applyStimulus(1'b1, 2'd2, 32'h30, 4'hF, 32'h0000_0000, 32'h0);
      applyStimulus(1'b1, 2'd0, 32'h31, 4'b0010, 32'h0000_5500, 32'h0);
      applyStimulus(1'b0, 2'd2, 32'h30, 4'h0, 32'h0, 32'h0000_5500);
      applyStimulus(1'b1, 2'd1, 32'h32, 4'b1100, 32'hBEEF_0000, 32'h0);
      applyStimulus(1'b0, 2'd2, 32'h30, 4'h0, 32'h0, 32'hBEEF_5500);
      drain();

      // Backpressure: six back-to-back reads with queue depth below latency.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 2'd2, 32'h40 + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i), 32'h0);
      end
      drain();
      accepted = 0;
      pattern  = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req   = (accepted < 6);
         wr    = 1'b0;
         size  = 2'd2;
         wstrb = 4'h0;
         addr  = 32'h40 + 32'(4 * accepted);
         pattern[9 - i] = addrOk;
         if (req && addrOk) begin
            expQ.push_back('{32'hC0DE_0000 + 32'(accepted), edgeCount + 1 + LAT});
            accepted++;
         end
      end
      drain();
      checkOutput("addrOkPattern", {22'b0, pattern}, 32'h0000_0333);
      checkOutput("acceptCount", 32'(accepted), 32'd6);
      checkOutput("preErrClear", {31'b0, err}, 32'h0);

      // Misaligned and out-of-range requests: still serviced, err goes sticky.
      applyStimulus(1'b1, 2'd2, 32'h00, 4'hF, 32'h0BAD_F00D, 32'h0);
      applyStimulus(1'b1, 2'd2, 32'h04, 4'hF, 32'h1234_5678, 32'h0);
      applyStimulus(1'b0, 2'd2, 32'h03, 4'h0, 32'h0, 32'h0BAD_F00D);
      drain();
      checkOutput("misalignErr", {31'b0, err}, 32'h1);
      applyStimulus(1'b0, 2'd2, 32'(DW * 4), 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 2'd2, 32'(DW * 4 + 4), 4'hF, 32'hFFFF_FFFF, 32'h0);
      applyStimulus(1'b0, 2'd2, 32'h04, 4'h0, 32'h0, 32'h1234_5678);
      drain();
      repeat (3) @(negedge clk);
      checkOutput("errSticky", {31'b0, err}, 32'h1);

      // Reset with two reads in flight: responses are discarded, memory persists.
      applyStimulus(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 32'h11AA_3344);
      @(negedge clk);
      req   = 1'b0;
      reset = 1'b1;
      expQ.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("midResetAddrOk", {31'b0, addrOk}, 32'h1);
      checkOutput("midResetErr", {31'b0, err}, 32'h0);
      checkOutput("midResetRdata", rdata, 32'h0);
      repeat (2 * LAT + 2) @(negedge clk);
      checkOutput("midResetDataOk", {31'b0, dataOk}, 32'h0);
      applyStimulus(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 32'h11AA_3344);
      drain();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
